led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator for the board's user LED bank. It is the successor to the fixed 12-LED Johnson trail. A programmable prescaler produces a step tick, and a pattern register advances once per tick in one of four selectable modes: Johnson trail, one-hot bounce, binary count, or hold. Direction, run/pause and synchronous clear are controllable, and output polarity is set by parameter. It sits between the top-level clock/control logic and the LED pins.

## Interface
- `N_LEDS`, 12: number of LEDs and pattern register width; must be 3 or more.
- `PRESCALE_W`, 24: width of the prescaler counter and of `period`.
- `ACTIVE_LOW`, 1: 1 drives `leds = ~pat`; 0 drives `leds = pat`.
- `clk`  in  1  system clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  2  step mode: 00 Johnson, 01 bounce, 10 binary, 11 hold.
- `dir`  in  1  Johnson/binary direction: 0 = right/up (default), 1 = left/down; ignored in bounce and hold.
- `period`  in  PRESCALE_W  a tick occurs every `period`+1 clocks.
- `run`  in  1  1 = advance; 0 = freeze prescaler and pattern.
- `clear`  in  1  synchronous restart of pattern and prescaler.
- `tick`  out  1  one-cycle pulse, high in the cycle the new pattern is first visible.
- `leds`  out  N_LEDS  LED drive; polarity set by `ACTIVE_LOW`.

## Operation
- State:
  - prescaler `cnt` [PRESCALE_W-1:0];
  - pattern `pat` [N_LEDS-1:0];
  - bounce direction `bdir` (0 = towards MSB);
  - registered `tick`.
- Reset (`rst_n`=0, asynchronous): `cnt`=0, `pat`=1, `bdir`=0, `tick`=0. Therefore `leds` = ~1 (all ones except bit 0) when `ACTIVE_LOW`=1, and `leds` = 1 otherwise.
- `clear`=1 at an edge: same values as reset, overriding everything else.
- Step condition: `run`=1 and `cnt` >= `period`. At that edge `cnt`<=0, `tick`<=1, and `pat`<=next(`pat`).
  - Otherwise `tick`<=0.
  - If `run`=1, `cnt`<=`cnt`+1. If `run`=0, `cnt` holds.
- The >= compare is mandatory. If `period` is lowered below the current `cnt`, a step occurs on the next edge with no 2^PRESCALE_W wrap.
- next(`pat`) by mode, sampled at the step edge:
  - Johnson, `dir`=0: {~pat[0], pat[N-1:1]}.
  - Johnson, `dir`=1: {pat[N-2:0], ~pat[N-1]}.
  - Johnson sequence from reset is 2·N ticks long. No normalisation is applied, so a non-Johnson `pat` is shifted as-is.
  - Bounce: if `pat` is not exactly one-hot, next = 1 and `bdir`<=0.
    - Otherwise, if `bdir`=0: shift left; when the result is bit N-1, set `bdir`<=1.
    - If `bdir`=1: shift right; when the result is bit 0, set `bdir`<=0.
    - Sequence length is 2·N−2 ticks; the end LEDs are lit for one tick only.
  - Binary: `pat`+1 if `dir`=0, `pat`−1 if `dir`=1, modulo 2^N.
  - Hold: `pat` unchanged; `tick` is still generated.
- Changes to `mode` and `dir` take effect only at a step edge; the pattern is carried across mode switches.
- `leds` is combinational from `pat` (an inverter only), so there is no extra register stage.

## Timing
- After reset release with `run`=1 and `period`=P: first `tick` and first pattern change at the (P+1)th rising edge, then every P+1 clocks.
- `period`=0: step on every clock, `tick` held high continuously.
- `run` falling: no step at that edge; `cnt` and `pat` frozen. `run` rising resumes from the frozen `cnt`.
- Latency from a `clear` edge to `pat`=1 and `tick`=0: visible in the following cycle.
- `clear` and a step condition at the same edge: `clear` wins and `tick`=0.
- Asynchronous reset asserted mid-period: outputs take their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, N=12, ACTIVE_LOW=1 → `leds`=0xFFE and `tick`=0. Release with `period`=3, `run`=1 → `tick` high at edges 4, 8, 12.
- Johnson, `dir`=0, `period`=0:
  - `pat` after ticks 1, 2, 3 = 0x000, 0x800, 0xC00;
  - tick 13 = 0xFFF;
  - tick 24 = 0x001 (period 24 confirmed).
  - Repeat with `dir`=1 → tick 2 = 0x001 and tick 13 = 0xFFF.
- Bounce, `period`=0, from reset:
  - tick 11 = 0x800;
  - tick 12 = 0x400;
  - tick 22 = 0x001;
  - tick 23 = 0x002.
  - Then force `pat`=0x0C0 via binary mode and switch to bounce → next tick = 0x001.
- Binary: `dir`=1 from reset → ticks give 0x000, 0xFFF, 0xFFE. `dir`=0 from 0xFFF → 0x000.
- Control edges, each with the required result:
  - `run`=0 for 10 cycles mid-period → no `tick` and `pat`/`cnt` unchanged.
  - `clear` coincident with a step → `pat`=0x001 and `tick`=0.
  - `period` dropped from 100 to 5 while `cnt`=50 → `tick` on the next edge.
- Async reset pulsed between clock edges during Johnson at 0xE00 → `leds`=0xFFE immediately; after release, normal stepping resumes from 0x001.

Source files
------------

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - Prescaled LED pattern generator (Johnson, bounce, binary, hold)
module led_pattern_gen #(
    parameter int N_LEDS     = 12,
    parameter int PRESCALE_W = 24,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  dir,
    input  logic [PRESCALE_W-1:0] period,
    input  logic                  run,
    input  logic                  clear,
    output logic                  tick,
    output logic [N_LEDS-1:0]     leds
);

    typedef enum logic [1:0] {
        MODE_JOHNSON = 2'b00,
        MODE_BOUNCE  = 2'b01,
        MODE_BINARY  = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_t;

    localparam logic [N_LEDS-1:0]     PAT_ONE = N_LEDS'(1);
    localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] cnt;
    logic [N_LEDS-1:0]     pat;
    logic                  bdir;
    logic                  tick_q;

    logic [N_LEDS-1:0]     pat_next;
    logic                  bdir_next;
    logic                  is_onehot;
    logic                  step;

    // >= rather than == so lowering period below cnt steps immediately instead of wrapping
    assign step      = run && (cnt >= period);
    assign is_onehot = (pat != '0) && ((pat & (pat - PAT_ONE)) == '0);

    // Next pattern and bounce direction for the currently selected mode
    always_comb begin
        pat_next  = pat;
        bdir_next = bdir;
        case (mode_t'(mode))
            MODE_JOHNSON: begin
                if (dir) pat_next = {pat[N_LEDS-2:0], ~pat[N_LEDS-1]};
                else     pat_next = {~pat[0], pat[N_LEDS-1:1]};
            end
            MODE_BOUNCE: begin
                if (!is_onehot) begin
                    // Recover from whatever pattern another mode left behind
                    pat_next  = PAT_ONE;
                    bdir_next = 1'b0;
                end else if (!bdir) begin
                    pat_next = pat << 1;
                    if (pat_next[N_LEDS-1]) bdir_next = 1'b1;
                end else begin
                    pat_next = pat >> 1;
                    if (pat_next[0]) bdir_next = 1'b0;
                end
            end
            MODE_BINARY: begin
                if (dir) pat_next = pat - PAT_ONE;
                else     pat_next = pat + PAT_ONE;
            end
            default: pat_next = pat;
        endcase
    end

    // Prescaler, pattern and tick registers; clear behaves like a synchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            pat    <= PAT_ONE;
            bdir   <= 1'b0;
            tick_q <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            pat    <= PAT_ONE;
            bdir   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= step;
            if (step) begin
                cnt  <= '0;
                pat  <= pat_next;
                bdir <= bdir_next;
            end else if (run) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    assign tick = tick_q;
    assign leds = ACTIVE_LOW ? ~pat : pat;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - Self-checking bench for led_pattern_gen against a behavioural model
module tb_led_pattern_gen;

    localparam int N    = 12;
    localparam int FULL = 1 << N;

    logic          clk;
    logic          rst_n;
    logic [1:0]    mode;
    logic          dir;
    logic [23:0]   period;
    logic          run;
    logic          clear;
    logic          tick;
    logic [N-1:0]  leds;

    int tests_run;
    int tests_failed;

    int m_cnt;
    int m_pat;
    bit m_bdir;
    bit m_tick;

    led_pattern_gen #(.N_LEDS(N), .PRESCALE_W(24), .ACTIVE_LOW(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (mode),
        .dir    (dir),
        .period (period),
        .run    (run),
        .clear  (clear),
        .tick   (tick),
        .leds   (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] lv(input logic [N-1:0] v);
        return ~v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_pat  = 1;
        m_bdir = 1'b0;
        m_tick = 1'b0;
    endtask

    function automatic int popcount(input int v);
        int c = 0;
        for (int i = 0; i < N; i++) if ((v >> i) % 2 == 1) c++;
        return c;
    endfunction

    task automatic model_advance();
        case (mode)
            2'd0: begin
                if (dir == 1'b0) m_pat = (m_pat / 2) + ((m_pat % 2 == 0) ? FULL / 2 : 0);
                else             m_pat = ((m_pat * 2) % FULL) + ((m_pat >= FULL / 2) ? 0 : 1);
            end
            2'd1: begin
                if (popcount(m_pat) != 1) begin
                    m_pat  = 1;
                    m_bdir = 1'b0;
                end else if (m_bdir == 1'b0) begin
                    m_pat = (m_pat * 2) % FULL;
                    if (m_pat == FULL / 2) m_bdir = 1'b1;
                end else begin
                    m_pat = m_pat / 2;
                    if (m_pat == 1) m_bdir = 1'b0;
                end
            end
            2'd2: begin
                if (dir == 1'b0) m_pat = (m_pat + 1) % FULL;
                else             m_pat = (m_pat + FULL - 1) % FULL;
            end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        if (!rst_n || clear) begin
            model_reset();
        end else if (run && m_cnt >= int'(period)) begin
            m_cnt  = 0;
            m_tick = 1'b1;
            model_advance();
        end else begin
            m_tick = 1'b0;
            if (run) m_cnt++;
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later
    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_leds", leds, lv(m_pat[N-1:0]));
        chk("model_tick", tick, m_tick);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0; run = 1'b0; clear = 1'b0; mode = 2'd0; dir = 1'b0; period = 24'd3;
        model_reset();
        repeat (3) clk_step();
        chk("reset_leds", leds, 12'hFFE);
        chk("reset_tick", tick, 1'b0);

        rst_n = 1'b1; run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            clk_step();
            chk("p3_tick", tick, (k % 4 == 0));
        end

        // Johnson right
        period = 24'd0; mode = 2'd0; dir = 1'b0; clear = 1'b1; clk_step(); clear = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            clk_step();
            if (k == 1)  chk("john_r_t1",  leds, lv(12'h000));
            if (k == 2)  chk("john_r_t2",  leds, lv(12'h800));
            if (k == 3)  chk("john_r_t3",  leds, lv(12'hC00));
            if (k == 13) chk("john_r_t13", leds, lv(12'hFFF));
            if (k == 24) chk("john_r_t24", leds, lv(12'h001));
        end

        // Johnson left, entered after one right step
        clear = 1'b1; clk_step(); clear = 1'b0;
        clk_step();
        dir = 1'b1;
        for (int k = 2; k <= 13; k++) begin
            clk_step();
            if (k == 2)  chk("john_l_t2",  leds, lv(12'h001));
            if (k == 13) chk("john_l_t13", leds, lv(12'hFFF));
        end

        // Bounce
        mode = 2'd1; dir = 1'b0; clear = 1'b1; clk_step(); clear = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            clk_step();
            if (k == 11) chk("bnc_t11", leds, lv(12'h800));
            if (k == 12) chk("bnc_t12", leds, lv(12'h400));
            if (k == 22) chk("bnc_t22", leds, lv(12'h001));
            if (k == 23) chk("bnc_t23", leds, lv(12'h002));
        end
        mode = 2'd2; clear = 1'b1; clk_step(); clear = 1'b0;
        repeat (191) clk_step();
        chk("bin_to_c0", leds, lv(12'h0C0));
        mode = 2'd1;
        clk_step();
        chk("bnc_recover", leds, lv(12'h001));

        // Binary down then up across wrap
        mode = 2'd2; dir = 1'b1; clear = 1'b1; clk_step(); clear = 1'b0;
        clk_step(); chk("bin_dn_1", leds, lv(12'h000));
        clk_step(); chk("bin_dn_2", leds, lv(12'hFFF));
        clk_step(); chk("bin_dn_3", leds, lv(12'hFFE));
        clear = 1'b1; clk_step(); clear = 1'b0;
        repeat (2) clk_step();
        dir = 1'b0;
        clk_step(); chk("bin_up_wrap", leds, lv(12'h000));

        // Pause mid-period
        mode = 2'd0; period = 24'd7; clear = 1'b1; clk_step(); clear = 1'b0;
        repeat (3) clk_step();
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            clk_step();
            chk("pause_tick", tick, 1'b0);
            chk("pause_leds", leds, lv(12'h001));
        end
        run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            clk_step();
            chk("resume_tick", tick, (k == 5));
        end
        chk("resume_leds", leds, lv(12'h000));

        // Clear coincident with a step
        period = 24'd0; mode = 2'd2;
        repeat (3) clk_step();
        clear = 1'b1; clk_step(); clear = 1'b0;
        chk("clr_step_leds", leds, lv(12'h001));
        chk("clr_step_tick", tick, 1'b0);

        // Period lowered below the running count
        period = 24'd100; clear = 1'b1; clk_step(); clear = 1'b0;
        repeat (50) clk_step();
        period = 24'd5;
        clk_step();
        chk("period_drop_tick", tick, 1'b1);

        // Asynchronous reset between edges
        mode = 2'd0; dir = 1'b0; period = 24'd0; clear = 1'b1; clk_step(); clear = 1'b0;
        repeat (4) clk_step();
        chk("async_pre", leds, lv(12'hE00));
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_leds", leds, 12'hFFE);
        chk("async_tick", tick, 1'b0);
        #1 rst_n = 1'b1;
        clk_step(); chk("async_resume1", leds, lv(12'h000));
        clk_step(); chk("async_resume2", leds, lv(12'h800));

        // Randomised control against the model
        for (int k = 0; k < 400; k++) begin
            mode   = 2'($urandom_range(0, 3));
            dir    = 1'($urandom_range(0, 1));
            run    = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 49) == 0);
            period = 24'($urandom_range(0, 3));
            clk_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
